// File: rtl/vend_pkg.sv
// Shared coin codes and scheduler FSM encoding for the vending front end.
package vend_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE = 2'b00;
  localparam coin_t COIN_HALF = 2'b01;
  localparam coin_t COIN_ONE  = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  function automatic logic is_coin(coin_t c);
    return (c == COIN_HALF) || (c == COIN_ONE);
  endfunction

endpackage

// File: rtl/vend_coin_sched_if.sv
// Coin acceptor slots on one side, vending core coin/drink/change on the other.
interface vend_coin_sched_if #(
  parameter int NSLOT = 2
);
  logic [NSLOT-1:0]   in_valid;
  logic [2*NSLOT-1:0] in_coin;
  logic [NSLOT-1:0]   in_ready;
  logic [1:0]         coin_o;
  logic               drink_i;
  logic               change_i;
  logic [NSLOT-1:0]   drink_o;
  logic [NSLOT-1:0]   change_o;

  modport master (
    output in_valid, in_coin, drink_i, change_i,
    input  in_ready, coin_o, drink_o, change_o
  );

  modport slave (
    input  in_valid, in_coin, drink_i, change_i,
    output in_ready, coin_o, drink_o, change_o
  );
endinterface

// File: rtl/vend_coin_fifo.sv
// Per-slot coin FIFO, 2 bits wide; head is visible combinationally for same-cycle issue.
module vend_coin_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  coin_t din,
  input  logic  pop,
  output coin_t head,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);

  coin_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; only the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vend_coin_sched.sv
// Locks the vending core to one coin slot per purchase, round-robin between purchases.
module vend_coin_sched
  import vend_pkg::*;
#(
  parameter  int NSLOT = 2,
  parameter  int DEPTH = 4,
  localparam int OW    = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  vend_coin_sched_if.slave bus,
  output logic [OW-1:0]   owner,
  output logic            busy,
  output logic [15:0]     vend_cnt,
  output logic [7:0]      err_cnt
);
  localparam int BW = $clog2(NSLOT + 1);

  state_t           state, state_nx;
  logic [OW-1:0]    owner_nx;
  logic [OW-1:0]    rr;
  logic [OW-1:0]    gnt;
  logic             gnt_found;
  logic [NSLOT-1:0] full, empty, push, pop, bad;
  coin_t            head [NSLOT];
  coin_t            coin;
  logic [BW-1:0]    n_bad;
  logic [8:0]       err_sum;
  logic [7:0]       err_nx;
  logic [NSLOT-1:0] drink_q, change_q;

  assign bus.in_ready = ~full;
  assign bus.coin_o   = coin;
  assign bus.drink_o  = drink_q;
  assign bus.change_o = change_q;
  assign busy         = (state == S_BUSY);

  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    // A handshake carrying 00 or 11 is consumed but never stored.
    assign push[k] = bus.in_valid[k] && !full[k] && is_coin(bus.in_coin[2*k +: 2]);
    assign bad[k]  = bus.in_valid[k] && !full[k] && !is_coin(bus.in_coin[2*k +: 2]);

    vend_coin_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .din   (bus.in_coin[2*k +: 2]),
      .pop   (pop[k]),
      .head  (head[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  always_comb begin
    n_bad = '0;
    for (int k = 0; k < NSLOT; k++) n_bad = n_bad + BW'(bad[k]);
    err_sum = {1'b0, err_cnt} + 9'(n_bad);
    err_nx  = err_sum[8] ? 8'hff : err_sum[7:0];
  end

  // Round-robin: first non-empty FIFO at or after rr.
  always_comb begin
    int j;
    gnt_found = 1'b0;
    gnt       = '0;
    for (int i = 0; i < NSLOT; i++) begin
      j = int'(rr) + i;
      if (j >= NSLOT) j = j - NSLOT;
      if (!gnt_found && !empty[j]) begin
        gnt_found = 1'b1;
        gnt       = OW'(j);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_nx = state;
    owner_nx = owner;
    pop      = '0;
    coin     = COIN_NONE;
    case (state)
      S_IDLE: begin
        if (gnt_found) begin
          coin     = head[gnt];
          pop[gnt] = 1'b1;
          owner_nx = gnt;
          state_nx = S_BUSY;
        end
      end
      S_BUSY: begin
        // The core ignores coins while dispensing, so hold the head back.
        if (bus.drink_i) begin
          state_nx = S_IDLE;
        end else if (!empty[owner]) begin
          coin       = head[owner];
          pop[owner] = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      owner    <= '0;
      rr       <= '0;
      vend_cnt <= '0;
      err_cnt  <= '0;
      drink_q  <= '0;
      change_q <= '0;
    end else begin
      state    <= state_nx;
      owner    <= owner_nx;
      err_cnt  <= err_nx;
      drink_q  <= '0;
      change_q <= '0;
      if (state == S_BUSY && bus.drink_i) begin
        drink_q[owner]  <= 1'b1;
        change_q[owner] <= bus.change_i;
        vend_cnt        <= vend_cnt + 16'd1;
        rr              <= (owner == OW'(NSLOT - 1)) ? '0 : owner + OW'(1);
      end
    end
  end

endmodule
